// File: rtl/serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor_if : start/busy/done operand and result bundle     |
// | Revision 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor : bit-serial unsigned a - b, LSB first, one bit/clk |
// | Revision 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int                 c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_diff;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_br;
  logic               r_borrow;
  logic               r_busy;
  logic               r_done;

  logic               w_d;
  logic               w_br_next;
  logic [WIDTH-1:0]   w_acc_next;

  assign w_d        = r_sa[0] ^ r_sb[0] ^ r_br;
  assign w_br_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
  // Each new bit enters at the MSB, so after WIDTH shifts bit 0 holds the first result bit.
  assign w_acc_next = {w_d, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_br     <= 1'b0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_br    <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_br_next;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_diff   <= w_acc_next;
            r_borrow <= w_br_next;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.diff   = r_diff;
  assign bus.borrow = r_borrow;
endmodule
`default_nettype wire
